// File: rtl/if_id_skid_stage_pkg.sv
//------------------------------------------------------------------------------
// Module   : if_id_skid_stage_pkg
// Brief    : Shared constants, state encoding and helpers for the IF->ID stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package if_id_skid_stage_pkg;

  localparam logic [31:0] c_NOP = 32'h0;

  localparam int c_DEF_LANES = 2;
  localparam int c_DEF_IW    = 32;
  localparam int c_DEF_AW    = 32;
  localparam int c_DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Bits needed to hold a count of 0..lanes set bits.
  function automatic int popcnt_width(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_skid_stage_lane_popcount.sv
//------------------------------------------------------------------------------
// Module   : if_id_skid_stage_lane_popcount
// Brief    : Combinational population count of a per-lane valid vector.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_id_skid_stage_lane_popcount
  import if_id_skid_stage_pkg::*;
#(
  parameter int LANES = c_DEF_LANES,
  parameter int CW    = popcnt_width(LANES)
) (
  input  logic [LANES-1:0] i_vec,
  output logic [CW-1:0]    o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < LANES; i++) begin
      o_count = o_count + CW'(i_vec[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_id_skid_stage.sv
//------------------------------------------------------------------------------
// Module   : if_id_skid_stage
// Brief    : Multi-lane IF->ID pipeline latch with 2-entry skid buffer,
//            registered upstream ready, synchronous flush and stall counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_id_skid_stage
  import if_id_skid_stage_pkg::*;
#(
  parameter int LANES = c_DEF_LANES,
  parameter int IW    = c_DEF_IW,
  parameter int AW    = c_DEF_AW,
  parameter int CNT_W = c_DEF_CNT_W
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                FLUSH,
  input  logic                STALL,
  input  logic                Valid_IF,
  output logic                Ready_IF,
  input  logic [LANES*IW-1:0] Instr_IF,
  input  logic [LANES-1:0]    Lane_Valid_IF,
  input  logic [AW-1:0]       Instr_PC_IF,
  output logic                Valid_OUT,
  output logic [LANES*IW-1:0] Instr_OUT,
  output logic [LANES-1:0]    Lane_Valid_OUT,
  output logic [AW-1:0]       Instr_PC_OUT,
  output logic [AW-1:0]       Instr_PC_Plus4,
  output logic [CNT_W-1:0]    Stall_Cnt
);

  localparam int CW = popcnt_width(LANES);

  state_t              r_state;
  logic                r_ready;
  logic [LANES*IW-1:0] r_main_instr;
  logic [LANES-1:0]    r_main_lv;
  logic [AW-1:0]       r_main_pc;
  logic [AW-1:0]       r_main_pc4;
  logic [LANES*IW-1:0] r_skid_instr;
  logic [LANES-1:0]    r_skid_lv;
  logic [AW-1:0]       r_skid_pc;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic                w_accept;
  logic                w_valid_out;
  logic                w_pop;
  logic                w_from_skid;
  logic [LANES*IW-1:0] w_in_instr;
  logic [LANES*IW-1:0] w_load_instr;
  logic [LANES-1:0]    w_load_lv;
  logic [AW-1:0]       w_load_pc;
  logic [AW-1:0]       w_load_pc4;
  logic [CW-1:0]       w_load_cnt;

  assign w_accept    = Valid_IF && r_ready;
  assign w_valid_out = (r_state != ST_EMPTY);
  assign w_pop       = w_valid_out && !STALL;

  // Invalid lanes are stored as NOP so ID never decodes stale bits.
  for (genvar g = 0; g < LANES; g++) begin : g_lane_mask
    assign w_in_instr[g*IW +: IW] = Lane_Valid_IF[g] ? Instr_IF[g*IW +: IW] : IW'(c_NOP);
  end

  // Main is only ever refilled from skid while FULL; otherwise from the input.
  assign w_from_skid  = (r_state == ST_FULL);
  assign w_load_instr = w_from_skid ? r_skid_instr : w_in_instr;
  assign w_load_lv    = w_from_skid ? r_skid_lv    : Lane_Valid_IF;
  assign w_load_pc    = w_from_skid ? r_skid_pc    : Instr_PC_IF;

  if_id_skid_stage_lane_popcount #(
    .LANES (LANES),
    .CW    (CW)
  ) u_lane_popcount (
    .i_vec   (w_load_lv),
    .o_count (w_load_cnt)
  );

  assign w_load_pc4 = w_load_pc + (AW'(w_load_cnt) << 2);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state      <= ST_EMPTY;
      r_ready      <= 1'b1;
      r_main_instr <= '0;
      r_main_lv    <= '0;
      r_main_pc    <= '0;
      r_main_pc4   <= '0;
      r_skid_instr <= '0;
      r_skid_lv    <= '0;
      r_skid_pc    <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (w_valid_out && STALL && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end

      if (FLUSH) begin
        r_state      <= ST_EMPTY;
        r_ready      <= 1'b1;
        r_main_instr <= '0;
        r_main_lv    <= '0;
        r_main_pc    <= '0;
        r_main_pc4   <= '0;
        r_skid_instr <= '0;
        r_skid_lv    <= '0;
        r_skid_pc    <= '0;
      end else begin
        unique case (r_state)
          ST_EMPTY: begin
            if (w_accept) begin
              r_state      <= ST_ONE;
              r_main_instr <= w_load_instr;
              r_main_lv    <= w_load_lv;
              r_main_pc    <= w_load_pc;
              r_main_pc4   <= w_load_pc4;
            end
          end
          ST_ONE: begin
            if (w_accept && w_pop) begin
              r_main_instr <= w_load_instr;
              r_main_lv    <= w_load_lv;
              r_main_pc    <= w_load_pc;
              r_main_pc4   <= w_load_pc4;
            end else if (w_accept) begin
              r_state      <= ST_FULL;
              r_ready      <= 1'b0;
              r_skid_instr <= w_in_instr;
              r_skid_lv    <= Lane_Valid_IF;
              r_skid_pc    <= Instr_PC_IF;
            end else if (w_pop) begin
              r_state      <= ST_EMPTY;
              r_main_instr <= '0;
              r_main_lv    <= '0;
              r_main_pc    <= '0;
              r_main_pc4   <= '0;
            end
          end
          ST_FULL: begin
            if (w_pop) begin
              r_state      <= ST_ONE;
              r_ready      <= 1'b1;
              r_main_instr <= w_load_instr;
              r_main_lv    <= w_load_lv;
              r_main_pc    <= w_load_pc;
              r_main_pc4   <= w_load_pc4;
              r_skid_instr <= '0;
              r_skid_lv    <= '0;
              r_skid_pc    <= '0;
            end
          end
          default: begin
            r_state <= ST_EMPTY;
            r_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign Ready_IF       = r_ready;
  assign Valid_OUT      = w_valid_out;
  assign Instr_OUT      = r_main_instr;
  assign Lane_Valid_OUT = r_main_lv;
  assign Instr_PC_OUT   = r_main_pc;
  assign Instr_PC_Plus4 = r_main_pc4;
  assign Stall_Cnt      = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_if_id_skid_stage.sv
//------------------------------------------------------------------------------
// Module   : tb_if_id_skid_stage
// Brief    : Self-checking bench for if_id_skid_stage with a queue-based model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_if_id_skid_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, stall, valid_if;
  logic        ready_if, valid_out;
  logic [63:0] instr_if, instr_out;
  logic [1:0]  lv_if, lv_out;
  logic [31:0] pc_if, pc_out, pc4_out;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_skid_stage #(.LANES(2), .IW(32), .AW(32), .CNT_W(16)) dut (
    .CLK(clk), .RESET(rst_n), .FLUSH(flush), .STALL(stall),
    .Valid_IF(valid_if), .Ready_IF(ready_if), .Instr_IF(instr_if),
    .Lane_Valid_IF(lv_if), .Instr_PC_IF(pc_if), .Valid_OUT(valid_out),
    .Instr_OUT(instr_out), .Lane_Valid_OUT(lv_out), .Instr_PC_OUT(pc_out),
    .Instr_PC_Plus4(pc4_out), .Stall_Cnt(stall_cnt)
  );

  // Reference: a FIFO of at most two beats; the head is what ID sees.
  typedef struct {
    logic [63:0] instr;
    logic [1:0]  lv;
    logic [31:0] pc;
  } beat_t;

  beat_t q[$];
  bit    m_ready = 1'b1;
  int    m_cnt   = 0;

  always @(posedge clk) begin
    beat_t b;
    bit    acc;
    if (!rst_n) begin
      q.delete();
      m_ready = 1'b1;
      m_cnt   = 0;
    end else begin
      if (q.size() > 0 && stall && m_cnt < 65535) m_cnt++;
      if (flush) begin
        q.delete();
        m_ready = 1'b1;
      end else begin
        acc = valid_if && m_ready;
        if (q.size() > 0 && !stall) void'(q.pop_front());
        if (acc) begin
          b.instr = lv_if[0] ? {32'h0, instr_if[31:0]} : 64'h0;
          if (lv_if[1]) b.instr[63:32] = instr_if[63:32];
          b.lv = lv_if;
          b.pc = pc_if;
          q.push_back(b);
        end
        m_ready = (q.size() < 2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [1:0] lv,
                       input logic [63:0] ins);
    valid_if = v;
    pc_if    = pc;
    lv_if    = lv;
    instr_if = ins;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; stall = 1'b0;
    drive(1'b1, 32'h40, 2'b11, 64'h1111_2222_3333_4444);
    tick(); tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    checks++; if (ready_if !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_if); end
    checks++; if ({instr_out, lv_out, pc_out, pc4_out, stall_cnt} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h/%b/%h/%h/%h want all 0", instr_out, lv_out, pc_out, pc4_out, stall_cnt);
    end
    rst_n = 1'b1;
    tick();
    checks++; if (valid_out !== 1'b1 || pc_out !== 32'h40 || pc4_out !== 32'h48) begin
      errors++; $display("FAIL reset_first_beat: got v=%b pc=%h pc4=%h want v=1 pc=40 pc4=48", valid_out, pc_out, pc4_out);
    end
    drive(1'b0, 32'h0, 2'b00, 64'h0);
    tick();
    checks++; if (valid_out !== 1'b0 || instr_out !== 64'h0) begin
      errors++; $display("FAIL reset_drain: got v=%b instr=%h want v=0 instr=0", valid_out, instr_out);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] pc;
    for (int i = 0; i < 3; i++) begin
      pc = 32'h100 + 32'(8 * i);
      drive(1'b1, pc, 2'b11, {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)});
      tick();
      checks++; if (valid_out !== 1'b1 || pc_out !== pc || pc4_out !== pc + 32'h8 || ready_if !== 1'b1) begin
        errors++; $display("FAIL stream_%0d: got v=%b pc=%h pc4=%h rdy=%b want v=1 pc=%h pc4=%h rdy=1",
                           i, valid_out, pc_out, pc4_out, ready_if, pc, pc + 32'h8);
      end
      checks++; if (instr_out !== {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)}) begin
        errors++; $display("FAIL stream_instr_%0d: got %h", i, instr_out);
      end
    end
    drive(1'b0, 32'h0, 2'b00, 64'h0);
    tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL stream_drain: got v=%b want 0", valid_out); end
  endtask

  task automatic test_skid();
    stall = 1'b1;
    drive(1'b1, 32'h200, 2'b11, 64'hAAAA_0001_AAAA_0000);
    tick();
    drive(1'b1, 32'h208, 2'b11, 64'hBBBB_0001_BBBB_0000);
    tick();
    checks++; if (ready_if !== 1'b0 || valid_out !== 1'b1 || pc_out !== 32'h200) begin
      errors++; $display("FAIL skid_full: got rdy=%b v=%b pc=%h want rdy=0 v=1 pc=200", ready_if, valid_out, pc_out);
    end
    drive(1'b1, 32'h210, 2'b11, 64'hCCCC_0001_CCCC_0000);
    tick();
    checks++; if (ready_if !== 1'b0 || pc_out !== 32'h200 || instr_out !== 64'hAAAA_0001_AAAA_0000) begin
      errors++; $display("FAIL skid_hold: got rdy=%b pc=%h instr=%h want rdy=0 pc=200", ready_if, pc_out, instr_out);
    end
    checks++; if (stall_cnt !== 16'(m_cnt) || m_cnt != 2) begin
      errors++; $display("FAIL skid_stall_cnt: got %0d want %0d (model %0d)", stall_cnt, 2, m_cnt);
    end
    stall = 1'b0;
    drive(1'b0, 32'h0, 2'b00, 64'h0);
    tick();
    checks++; if (valid_out !== 1'b1 || pc_out !== 32'h208 || instr_out !== 64'hBBBB_0001_BBBB_0000 || ready_if !== 1'b1) begin
      errors++; $display("FAIL skid_release_b: got v=%b pc=%h instr=%h rdy=%b want v=1 pc=208 rdy=1",
                         valid_out, pc_out, instr_out, ready_if);
    end
    tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL skid_drain: got v=%b want 0 (pc=%h)", valid_out, pc_out); end
  endtask

  task automatic test_partial();
    drive(1'b1, 32'h300, 2'b01, 64'hDEAD_BEEF_0000_0013);
    tick();
    checks++; if (instr_out !== 64'h0000_0000_0000_0013 || lv_out !== 2'b01 || pc4_out !== 32'h304) begin
      errors++; $display("FAIL partial: got instr=%h lv=%b pc4=%h want instr=0000000000000013 lv=01 pc4=304",
                         instr_out, lv_out, pc4_out);
    end
    drive(1'b1, 32'h310, 2'b00, 64'h1234_5678_9ABC_DEF0);
    tick();
    checks++; if (valid_out !== 1'b1 || instr_out !== 64'h0 || lv_out !== 2'b00 || pc4_out !== 32'h310) begin
      errors++; $display("FAIL bubble_beat: got v=%b instr=%h lv=%b pc4=%h want v=1 instr=0 lv=00 pc4=310",
                         valid_out, instr_out, lv_out, pc4_out);
    end
    drive(1'b0, 32'h0, 2'b00, 64'h0);
    tick();
  endtask

  task automatic test_flush();
    stall = 1'b1;
    drive(1'b1, 32'h380, 2'b11, 64'h1);
    tick();
    drive(1'b1, 32'h388, 2'b11, 64'h2);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h400, 2'b11, 64'h4);
    tick();
    checks++; if (valid_out !== 1'b0 || ready_if !== 1'b1 || {instr_out, lv_out, pc_out, pc4_out} !== '0) begin
      errors++; $display("FAIL flush: got v=%b rdy=%b instr=%h pc=%h pc4=%h want v=0 rdy=1 outputs 0",
                         valid_out, ready_if, instr_out, pc_out, pc4_out);
    end
    checks++; if (stall_cnt !== 16'(m_cnt) || stall_cnt === 16'h0) begin
      errors++; $display("FAIL flush_keeps_cnt: got %0d want %0d", stall_cnt, m_cnt);
    end
    flush = 1'b0; stall = 1'b0;
    drive(1'b0, 32'h0, 2'b00, 64'h0);
    tick();
    checks++; if (valid_out !== 1'b0 || pc_out === 32'h400) begin
      errors++; $display("FAIL flush_discard: got v=%b pc=%h want v=0", valid_out, pc_out);
    end
  endtask

  task automatic test_wrap_counter();
    drive(1'b1, 32'hFFFF_FFF8, 2'b11, 64'h5);
    tick();
    checks++; if (pc4_out !== 32'h0 || pc_out !== 32'hFFFF_FFF8) begin
      errors++; $display("FAIL pc_wrap: got pc=%h pc4=%h want pc=fffffff8 pc4=0", pc_out, pc4_out);
    end
    stall = 1'b1;
    drive(1'b0, 32'h0, 2'b00, 64'h0);
    repeat (70000) @(posedge clk);
    #1;
    checks++; if (stall_cnt !== 16'hFFFF || m_cnt != 65535) begin
      errors++; $display("FAIL stall_cnt_sat: got %h want ffff (model %0d)", stall_cnt, m_cnt);
    end
    checks++; if (valid_out !== 1'b1 || pc_out !== 32'hFFFF_FFF8) begin
      errors++; $display("FAIL stall_hold: got v=%b pc=%h want v=1 pc=fffffff8", valid_out, pc_out);
    end
    stall = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [1:0]  lvs [3] = '{2'b00, 2'b01, 2'b11};
    logic [63:0] e_instr;
    logic [1:0]  e_lv;
    logic [31:0] e_pc, e_pc4;
    bit          e_v;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      stall = ($urandom_range(0, 99) < 35);
      flush = ($urandom_range(0, 99) < 4);
      drive($urandom_range(0, 99) < 70, $urandom, lvs[$urandom_range(0, 2)], {$urandom, $urandom});
      tick();
      e_v = (q.size() > 0);
      if (e_v) begin
        e_instr = q[0].instr; e_lv = q[0].lv; e_pc = q[0].pc;
        e_pc4 = q[0].pc + 32'(4 * $countones(q[0].lv));
      end else begin
        e_instr = '0; e_lv = '0; e_pc = '0; e_pc4 = '0;
      end
      checks++; if (valid_out !== e_v || ready_if !== m_ready) begin
        errors++; $display("FAIL rand_ctrl[%0d]: got v=%b rdy=%b want v=%b rdy=%b", i, valid_out, ready_if, e_v, m_ready);
      end
      checks++; if (instr_out !== e_instr || lv_out !== e_lv) begin
        errors++; $display("FAIL rand_data[%0d]: got %h/%b want %h/%b", i, instr_out, lv_out, e_instr, e_lv);
      end
      checks++; if (pc_out !== e_pc || pc4_out !== e_pc4) begin
        errors++; $display("FAIL rand_pc[%0d]: got %h/%h want %h/%h", i, pc_out, pc4_out, e_pc, e_pc4);
      end
      checks++; if (stall_cnt !== 16'(m_cnt)) begin
        errors++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", i, stall_cnt, m_cnt);
      end
    end
    flush = 1'b0; stall = 1'b0;
    drive(1'b0, 32'h0, 2'b00, 64'h0);
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_skid();
    test_partial();
    test_flush();
    test_wrap_counter();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
